// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Purpose  : Shared light encodings, debounce state encoding and helpers
//            used by the traffic light controller and its sensor blocks.
// Revision : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // One-hot light encodings: [2]=green, [1]=yellow, [0]=red
    localparam logic [2:0] LIGHT_GREEN  = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b001;

    // Loop detector debounce states
    typedef enum logic [1:0] {
        DEB_IDLE    = 2'd0,
        DEB_ARM     = 2'd1,
        DEB_PRESENT = 2'd2,
        DEB_REL     = 2'd3
    } deb_state_t;

    // True when exactly one bit of a 3-bit light value is set
    function automatic logic is_one_hot3(input logic [2:0] v);
        return (v != 3'b000) && ((v & (v - 3'b001)) == 3'b000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lr_car_sensor_if.sv
`default_nettype none
// ============================================================================
// Module   : lr_car_sensor_if
// Purpose  : Signal bundle between the local-road car sensor, the loop
//            detector and the traffic light controller.
// Revision : 1.0 - initial release
// ============================================================================
interface lr_car_sensor_if #(
    parameter int CNT_W = 4
);
    logic             loop_raw;
    logic [2:0]       lr_light;
    logic             lr_has_car;
    logic [CNT_W-1:0] queue_cnt;
    logic             arrive;
    logic             depart;
    logic             overflow;
    logic             light_err;

    // Sensor side: consumes loop and light, produces request and status
    modport slave (
        input  loop_raw,
        input  lr_light,
        output lr_has_car,
        output queue_cnt,
        output arrive,
        output depart,
        output overflow,
        output light_err
    );

    // Environment / controller side
    modport master (
        output loop_raw,
        output lr_light,
        input  lr_has_car,
        input  queue_cnt,
        input  arrive,
        input  depart,
        input  overflow,
        input  light_err
    );
endinterface
`default_nettype wire

// File: rtl/lr_loop_debounce.sv
`default_nettype none
// ============================================================================
// Module   : lr_loop_debounce
// Purpose  : Two-flop synchronizer plus debounce FSM for the raw loop
//            detector. Emits one arrive pulse per accepted car.
// Revision : 1.0 - initial release
// ============================================================================
module lr_loop_debounce
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  loop_raw,
    output logic arrive_set,   // arrive is asserted at the coming edge
    output logic arrive        // registered one-cycle arrival pulse
);

    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE - 1);

    logic       s1;
    logic       s2;
    deb_state_t state;
    deb_state_t state_nxt;
    logic [3:0] deb_cnt;
    logic [3:0] deb_cnt_nxt;

    // Bring the asynchronous loop input into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= loop_raw;
            s2 <= s1;
        end
    end

    // Debounce state, counter and arrival pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= DEB_IDLE;
            deb_cnt <= 4'd0;
            arrive  <= 1'b0;
        end else begin
            state   <= state_nxt;
            deb_cnt <= deb_cnt_nxt;
            arrive  <= arrive_set;
        end
    end

    // Next-state: a level must persist DEBOUNCE cycles beyond the first
    // sample before an edge is accepted; a brief drop while present is
    // absorbed by REL so a lingering car never arrives twice.
    always_comb begin
        state_nxt   = state;
        deb_cnt_nxt = deb_cnt;
        arrive_set  = 1'b0;
        case (state)
            DEB_IDLE: begin
                if (s2) begin
                    state_nxt   = DEB_ARM;
                    deb_cnt_nxt = 4'd0;
                end
            end
            DEB_ARM: begin
                if (!s2) begin
                    state_nxt   = DEB_IDLE;
                    deb_cnt_nxt = 4'd0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt   = DEB_PRESENT;
                    deb_cnt_nxt = 4'd0;
                    arrive_set  = 1'b1;
                end else begin
                    deb_cnt_nxt = deb_cnt + 4'd1;
                end
            end
            DEB_PRESENT: begin
                if (!s2) begin
                    state_nxt   = DEB_REL;
                    deb_cnt_nxt = 4'd0;
                end
            end
            DEB_REL: begin
                if (s2) begin
                    state_nxt   = DEB_PRESENT;
                    deb_cnt_nxt = 4'd0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt   = DEB_IDLE;
                    deb_cnt_nxt = 4'd0;
                end else begin
                    deb_cnt_nxt = deb_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt   = DEB_IDLE;
                deb_cnt_nxt = 4'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lr_car_sensor.sv
`default_nettype none
// ============================================================================
// Module   : lr_car_sensor
// Purpose  : Local-road vehicle detector and queue model. Debounces the
//            loop, counts waiting cars, retires them on green and raises
//            lr_has_car towards the traffic light controller.
// Revision : 1.0 - initial release
// ============================================================================
module lr_car_sensor
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE      = 4,
    parameter int DEPART_CYCLES = 3,
    parameter int QUEUE_MAX     = 15,
    parameter int CNT_W         = 4
) (
    input  wire             clk,
    input  wire             rst_n,
    lr_car_sensor_if.slave  bus
);

    localparam logic [CNT_W-1:0] Q_MAX    = CNT_W'(QUEUE_MAX);
    localparam logic [CNT_W-1:0] Q_ZERO   = '0;
    localparam logic [3:0]       DEP_LAST = 4'(DEPART_CYCLES - 1);

    logic             arrive_set;
    logic             arrive;
    logic             green;
    logic             light_bad;
    logic             dep_run;
    logic             depart_set;
    logic [3:0]       dep_cnt;
    logic [3:0]       dep_cnt_nxt;
    logic             depart;
    logic [CNT_W-1:0] queue_cnt;
    logic [CNT_W-1:0] queue_nxt;
    logic             ovf_set;
    logic             overflow;
    logic             light_err;

    lr_loop_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .loop_raw   (bus.loop_raw),
        .arrive_set (arrive_set),
        .arrive     (arrive)
    );

    // Departure timer: only a clean green with cars waiting advances it;
    // anything else discards the partial interval.
    always_comb begin
        green       = (bus.lr_light == LIGHT_GREEN);
        light_bad   = !is_one_hot3(bus.lr_light);
        dep_run     = green && (queue_cnt != Q_ZERO);
        depart_set  = dep_run && (dep_cnt == DEP_LAST);
        dep_cnt_nxt = 4'd0;
        if (dep_run && !depart_set) begin
            dep_cnt_nxt = dep_cnt + 4'd1;
        end
    end

    // Queue update using the same-edge arrive/depart decisions; a
    // simultaneous pair cancels and never counts as overflow.
    always_comb begin
        queue_nxt = queue_cnt;
        ovf_set   = 1'b0;
        if (arrive_set && !depart_set) begin
            if (queue_cnt == Q_MAX) begin
                ovf_set = 1'b1;
            end else begin
                queue_nxt = queue_cnt + CNT_W'(1);
            end
        end else if (depart_set && !arrive_set) begin
            queue_nxt = queue_cnt - CNT_W'(1);
        end
    end

    // Timer, queue count, depart pulse and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dep_cnt   <= 4'd0;
            depart    <= 1'b0;
            queue_cnt <= '0;
            overflow  <= 1'b0;
            light_err <= 1'b0;
        end else begin
            dep_cnt   <= dep_cnt_nxt;
            depart    <= depart_set;
            queue_cnt <= queue_nxt;
            overflow  <= overflow | ovf_set;
            light_err <= light_err | light_bad;
        end
    end

    // Output mapping; the request decodes straight from the registered count
    always_comb begin
        bus.lr_has_car = (queue_cnt != Q_ZERO);
        bus.queue_cnt  = queue_cnt;
        bus.arrive     = arrive;
        bus.depart     = depart;
        bus.overflow   = overflow;
        bus.light_err  = light_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_lr_car_sensor.sv
`default_nettype none
// ============================================================================
// Module   : tb_lr_car_sensor
// Purpose  : Self-checking bench for lr_car_sensor: run-length reference
//            model, event scoreboard and directed boundary checks.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lr_car_sensor;
    import traffic_pkg::*;

    localparam int DEBOUNCE      = 4;
    localparam int DEPART_CYCLES = 3;
    localparam int QUEUE_MAX     = 15;
    localparam int CNT_W         = 4;
    localparam logic [2:0] GRN = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] RED = 3'b001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lr_car_sensor_if #(.CNT_W(CNT_W)) bus();

    lr_car_sensor #(
        .DEBOUNCE      (DEBOUNCE),
        .DEPART_CYCLES (DEPART_CYCLES),
        .QUEUE_MAX     (QUEUE_MAX),
        .CNT_W         (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit arr;
        bit dep;
        int q;
        bit ovf;
        bit err;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // Reference model state: loop samples delayed two clocks, run lengths
    // of the delayed level, car-present flag, green streak, queue, flags.
    bit dly[2];
    bit m_present;
    int m_hi, m_lo, m_streak, m_q;
    bit m_ovf, m_err;

    task automatic model_reset();
        dly[0] = 0; dly[1] = 0;
        m_present = 0; m_hi = 0; m_lo = 0; m_streak = 0; m_q = 0;
        m_ovf = 0; m_err = 0;
        sb.delete();
    endtask

    // Apply inputs for the next edge, predict its effect, then advance to
    // just after that edge.
    task automatic step(input bit loop, input logic [2:0] light);
        bit seen, arr, dep;
        bus.loop_raw = loop;
        bus.lr_light = light;
        seen   = dly[1];
        dly[1] = dly[0];
        dly[0] = loop;
        if (seen) begin m_hi++; m_lo = 0; end
        else      begin m_lo++; m_hi = 0; end
        arr = !m_present && (m_hi == DEBOUNCE + 1);
        if (arr) m_present = 1;
        if (m_present && (m_lo == DEBOUNCE + 1)) m_present = 0;
        if ($countones(light) != 1) m_err = 1;
        dep = 0;
        if (light == GRN && m_q > 0) begin
            m_streak++;
            if (m_streak == DEPART_CYCLES) begin dep = 1; m_streak = 0; end
        end else begin
            m_streak = 0;
        end
        if (arr && !dep) begin
            if (m_q == QUEUE_MAX) m_ovf = 1;
            else m_q++;
        end else if (dep && !arr) begin
            m_q--;
        end
        if (arr || dep) sb.push_back('{arr, dep, m_q, m_ovf, m_err});
        @(posedge clk);
        #1;
    endtask

    task automatic car(input logic [2:0] light);
        repeat (6) step(1'b1, light);
        repeat (7) step(1'b0, light);
    endtask

    task automatic check_state(input string name);
        total++;
        if (int'(bus.queue_cnt) != m_q || bus.lr_has_car !== (m_q != 0) ||
            bus.overflow !== m_ovf || bus.light_err !== m_err) begin
            bad++;
            $display("FAIL %s: got q=%0d has_car=%b ovf=%b err=%b, want q=%0d has_car=%b ovf=%b err=%b",
                     name, bus.queue_cnt, bus.lr_has_car, bus.overflow, bus.light_err,
                     m_q, (m_q != 0), m_ovf, m_err);
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if (bus.queue_cnt !== '0 || bus.lr_has_car !== 1'b0 || bus.arrive !== 1'b0 ||
            bus.depart !== 1'b0 || bus.overflow !== 1'b0 || bus.light_err !== 1'b0) begin
            bad++;
            $display("FAIL %s: got q=%0d has_car=%b arr=%b dep=%b ovf=%b err=%b, want all 0",
                     name, bus.queue_cnt, bus.lr_has_car, bus.arrive, bus.depart,
                     bus.overflow, bus.light_err);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // Monitor: every arrive/depart pulse the DUT presents is matched
    // against the oldest predicted event.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (bus.arrive || bus.depart)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got arrive=%b depart=%b q=%0d, want no event",
                         bus.arrive, bus.depart, bus.queue_cnt);
            end else begin
                e = sb.pop_front();
                if (bus.arrive !== e.arr || bus.depart !== e.dep ||
                    int'(bus.queue_cnt) != e.q || bus.lr_has_car !== (e.q != 0) ||
                    bus.overflow !== e.ovf || bus.light_err !== e.err) begin
                    bad++;
                    $display("FAIL event: got arr=%b dep=%b q=%0d has=%b ovf=%b err=%b, want arr=%b dep=%b q=%0d has=%b ovf=%b err=%b",
                             bus.arrive, bus.depart, bus.queue_cnt, bus.lr_has_car,
                             bus.overflow, bus.light_err,
                             e.arr, e.dep, e.q, (e.q != 0), e.ovf, e.err);
                end
            end
        end
    end

    initial begin
        bus.loop_raw = 1'b0;
        bus.lr_light = RED;
        model_reset();
        #12;
        check_zero("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("after_reset");

        // Short pulse of DEBOUNCE samples is rejected
        repeat (4)  step(1'b1, RED);
        repeat (12) step(1'b0, RED);
        check_state("glitch_4");
        check_bit("glitch_q0", bus.queue_cnt == '0, 1'b1);

        // Long hold: exactly one arrival, at edge DEBOUNCE+2
        for (int i = 0; i < 10; i++) begin
            step(1'b1, RED);
            if (i == 5) check_bit("arrive_edge5", bus.arrive, 1'b0);
            if (i == 6) check_bit("arrive_edge6", bus.arrive, 1'b1);
        end
        repeat (12) step(1'b0, RED);
        check_state("hold_10");
        check_bit("hold_has_car", bus.lr_has_car, 1'b1);

        // Three cars drain at green cycles 3, 6, 9
        car(RED);
        car(RED);
        check_state("three_queued");
        for (int g = 1; g <= 12; g++) begin
            step(1'b0, GRN);
            if (g % 3 == 0) check_bit($sformatf("depart_g%0d", g), bus.depart, (g <= 9));
        end
        check_state("drained");

        // Partial green interval does not carry over a yellow
        car(RED);
        step(1'b0, GRN);
        step(1'b0, GRN);
        step(1'b0, YEL);
        for (int g = 1; g <= 3; g++) begin
            step(1'b0, GRN);
            check_bit($sformatf("restart_g%0d", g), bus.depart, (g == 3));
        end
        check_state("partial_green");

        // Arrival and departure on the same edge leave the count unchanged
        car(RED);
        car(RED);
        check_state("two_queued");
        for (int i = 0; i < 7; i++) step(1'b1, (i >= 4) ? GRN : RED);
        check_bit("simul_arrive", bus.arrive, 1'b1);
        check_bit("simul_depart", bus.depart, 1'b1);
        check_bit("simul_q2", bus.queue_cnt == 4'd2, 1'b1);
        repeat (8) step(1'b0, RED);
        check_state("simultaneous");

        // Saturation and sticky overflow
        repeat (20) step(1'b0, GRN);
        check_state("pre_saturate");
        repeat (15) car(RED);
        check_state("fifteen");
        car(RED);
        check_state("saturated");
        check_bit("overflow_set", bus.overflow, 1'b1);
        repeat (60) step(1'b0, GRN);
        check_state("ovf_sticky_after_drain");

        // Illegal light value
        repeat (4) car(RED);
        step(1'b0, GRN);
        step(1'b0, GRN);
        step(1'b0, 3'b110);
        check_bit("illegal_err", bus.light_err, 1'b1);
        check_bit("illegal_no_depart", bus.depart, 1'b0);
        check_state("illegal_light");
        step(1'b0, GRN);
        step(1'b0, GRN);
        check_state("illegal_restart");

        // Randomized traffic with mostly legal lights
        begin
            bit lvl;
            logic [2:0] lt;
            int n;
            lvl = 0;
            lt  = RED;
            n   = 0;
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 5) == 0) lvl = $urandom_range(0, 1);
                if (n == 0) begin
                    n = $urandom_range(1, 12);
                    case ($urandom_range(0, 19))
                        0:       lt = 3'($urandom_range(0, 7));
                        1, 2, 3: lt = YEL;
                        4, 5, 6, 7, 8, 9: lt = RED;
                        default: lt = GRN;
                    endcase
                end
                n--;
                step(lvl, lt);
            end
        end
        repeat (12) step(1'b0, RED);
        check_state("random");

        // Asynchronous reset mid-operation discards a queue of five
        repeat (80) step(1'b0, GRN);
        repeat (5) car(RED);
        check_state("five_queued");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("post_reset");
        car(RED);
        check_state("post_reset_car");

        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending events, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
